bcd_down_timer: RTL and testbench
=================================

Name: bcd_down_timer

Overview:
Synchronous multi-digit BCD down-counter/timer, the counting-down counterpart of the lab's decade up-counters.
- Loads a BCD preset and decrements once per prescaled tick while running.
- Flags completion when the count reaches zero.
- Drives the seven-segment display path directly with packed BCD digits.

Parameters:
DIGITS, 2, number of BCD digits (1..4); digit 0 is least significant
TICK_DIV, 50000000, clk cycles per decrement (>=2); benches use 4

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
load  input  1  one-cycle pulse, capture load_val
load_val  input  4*DIGITS  packed BCD preset, digit i at [4i+3:4i]
start  input  1  one-cycle pulse, begin/resume counting
pause  input  1  one-cycle pulse, suspend counting
count  output  4*DIGITS  current packed BCD value
state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
zero  output  1  high whenever count == 0
done  output  1  one-cycle pulse when count reaches 0 in RUN

Behaviour:
- Reset (rst low, asynchronous): count=0, state=IDLE, prescaler=0, done=0, reload register=0. zero=1.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - Holds its value in PAUSE.
  - Cleared on load and on the IDLE->RUN transition.
  - The tick is the cycle in which the prescaler equals TICK_DIV-1.
- Decrement: on a tick in RUN, count updates on that clock edge, so the new value is visible the next cycle.
  - Digit 0 decrements.
  - Any digit at 0 wraps to 9 and borrows from the next digit.
  - Borrow ripples within one cycle (synchronous, not rippled clocks).
- Load:
  - Highest priority in every state, including DONE.
  - Next cycle: count=load_val, reload register=load_val, state=IDLE, prescaler=0, done=0.
  - Any load digit >9 is clamped to 9 (e.g. 8'h3A loads 8'h39).
- FSM (when load is not asserted):
  - IDLE: start with count!=0 -> RUN; start with count==0 -> stay IDLE; pause ignored.
  - RUN:
    - pause -> PAUSE (pause wins if start and pause coincide).
    - A tick with count==1 makes count=0, asserts done for exactly one cycle (registered with count), and moves to DONE.
  - PAUSE: start -> RUN, prescaler resumes from its held value; pause ignored.
  - DONE: count held at 0; start and pause ignored; only load or reset leaves DONE.
- Simultaneous events:
  - tick+pause in the same cycle: the decrement occurs and state goes to PAUSE.
  - tick+load in the same cycle: load wins.
- zero is combinational from count.
- Reset mid-run forces reset values immediately; no pending done pulse survives.

Optional Feature:
- Macro: BCD_TIMER_AUTO_RELOAD_EN.
- Defined:
  - On reaching 0 in RUN, done pulses but state stays RUN.
  - The next tick loads the reload register instead of decrementing, and counting continues (periodic timer).
  - If the reload register is 0, the block goes to DONE as without the feature.
- Not defined: behaviour exactly as above; the reload register may be optimised away.

Test Plan:
- Reset: hold rst=0 with clk running and random inputs -> count=8'h00, state=0, done=0, zero=1; release, then 10 idle cycles -> unchanged.
- Basic countdown, DIGITS=2, TICK_DIV=4: load 8'h12, start -> count sequence 12,11,10,09,08,...,01,00 with each value lasting 4 cycles. done high exactly one cycle coincident with count=00; state=3; start afterwards -> still 3.
- Clamp and borrow:
  - load 8'h3A -> count=8'h39.
  - load 8'h100-style across digits, e.g. DIGITS=3 load 12'h100, start -> 100 then 099.
- Pause/resume: run from 8'h10, pause when count=07 -> count holds 07 for 20 cycles, state=2; start -> next decrement after the remaining prescaler cycles (total 4 RUN cycles per value including those before the pause).
- Load during RUN and start on zero:
  - load 8'h20 at count=05 -> count=20, state=0 next cycle.
  - load 8'h00 then start -> state stays 0, done never asserts.
- With BCD_TIMER_AUTO_RELOAD_EN: load 8'h02, start -> 02,01,00 (done pulse, state=1) then 02,01,00 repeating with done pulsing every 12 cycles.

Source files
------------

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - multi-digit BCD down-counter/timer with prescaled tick and done pulse
// Optional periodic reload when BCD_TIMER_AUTO_RELOAD_EN is defined.
module bcd_down_timer #(
   parameter int DIGITS   = 2,
   parameter int TICK_DIV = 50000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  pause,
   output logic [4*DIGITS-1:0]   count,
   output logic [1:0]            state,
   output logic                  zero,
   output logic                  done
);

   localparam int W  = 4 * DIGITS;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [W-1:0]  ONE        = W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         state_q;
   logic [W-1:0]   count_q;
   logic [PW-1:0]  presc_q;
   logic           done_q;
   logic           tick;
   logic [W-1:0]   count_dec;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
   logic [W-1:0]   reload_q;
`endif

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   assign tick      = (state_q == S_RUN) && (presc_q == PRESC_LAST);
   assign count_dec = bcd_dec(count_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         presc_q  <= '0;
         done_q   <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (load) begin
            count_q  <= bcd_clamp(load_val);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            reload_q <= bcd_clamp(load_val);
`endif
            state_q  <= S_IDLE;
            presc_q  <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start && (count_q != '0)) begin
                     state_q <= S_RUN;
                     presc_q <= '0;
                  end
               end
               S_RUN: begin
                  presc_q <= tick ? '0 : presc_q + 1'b1;
                  if (pause) state_q <= S_PAUSE;
                  if (tick) begin
                     if (count_q == ONE) begin
                        // Reaching zero ends the run even if pause arrives on the same tick.
                        count_q <= count_dec;
                        done_q  <= 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                        if (reload_q == '0) state_q <= S_DONE;
`else
                        state_q <= S_DONE;
`endif
                     end
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                     else if (count_q == '0) begin
                        count_q <= reload_q;
                     end
`endif
                     else begin
                        count_q <= count_dec;
                     end
                  end
               end
               S_PAUSE: begin
                  if (start) state_q <= S_RUN;
               end
               default: begin
                  state_q <= S_DONE;
               end
            endcase
         end
      end
   end

   assign count = count_q;
   assign state = state_q;
   assign zero  = (count_q == '0);
   assign done  = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb/tb_bcd_down_timer.sv - directed self-checking bench for bcd_down_timer (DIGITS=2 and 3, TICK_DIV=4)
module tb_bcd_down_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        load, start, pause;
   logic [7:0]  load_val;
   logic [7:0]  count;
   logic [1:0]  state;
   logic        zero, done;

   logic        load3, start3, pause3;
   logic [11:0] load_val3;
   logic [11:0] count3;
   logic [1:0]  state3;
   logic        zero3, done3;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   bcd_down_timer #(.DIGITS(2), .TICK_DIV(4)) u_dut (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
      .pause(pause), .count(count), .state(state), .zero(zero), .done(done)
   );

   bcd_down_timer #(.DIGITS(3), .TICK_DIV(4)) u_dut3 (
      .clk(clk), .rst(rst), .load(load3), .load_val(load_val3), .start(start3),
      .pause(pause3), .count(count3), .state(state3), .zero(zero3), .done(done3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1'b1; load_val = v;
      step();
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   function automatic logic [7:0] to_bcd(input int d);
      return {4'(d / 10), 4'(d % 10)};
   endfunction

   initial begin
      logic        seen_done;
      logic [7:0]  ar_seq [3];
      rst = 1'b0; load = 0; start = 0; pause = 0; load_val = '0;
      load3 = 0; start3 = 0; pause3 = 0; load_val3 = '0;

      // reset held with random inputs
      for (int i = 0; i < 5; i++) begin
         load = 1'($urandom); start = 1'($urandom); pause = 1'($urandom);
         load_val = 8'($urandom); load3 = 1'($urandom); load_val3 = 12'($urandom);
         step();
      end
      check("rst_count", count, 8'h00);
      check("rst_state", state, 2'd0);
      check("rst_done", done, 1'b0);
      check("rst_zero", zero, 1'b1);
      load = 0; start = 0; pause = 0; load3 = 0;
      rst = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("idle_count", count, 8'h00);
      check("idle_state", state, 2'd0);
      check("idle_zero", zero, 1'b1);

      // basic countdown 12 -> 00
      do_load(8'h12);
      check("load12", count, 8'h12);
      do_start();
      for (int k = 0; k < 48; k++) begin
         check("cd_count", count, to_bcd(12 - k / 4));
         check("cd_done", done, 1'b0);
         step();
      end
      check("cd_zero_count", count, 8'h00);
      check("cd_done_pulse", done, 1'b1);
      check("cd_zero_flag", zero, 1'b1);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      check("cd_state_ar", state, 2'd1);
      step();
      check("cd_done_off", done, 1'b0);
`else
      check("cd_state_done", state, 2'd3);
      step();
      check("cd_done_off", done, 1'b0);
      do_start();
      check("done_ignore_start", state, 2'd3);
      check("done_hold_count", count, 8'h00);
`endif

      // clamp
      do_load(8'h3A);
      check("clamp_3A", count, 8'h39);
      check("clamp_state", state, 2'd0);
      do_load(8'hFF);
      check("clamp_FF", count, 8'h99);

      // 3-digit borrow across two digits
      load3 = 1'b1; load_val3 = 12'h100; step(); load3 = 1'b0;
      start3 = 1'b1; step(); start3 = 1'b0;
      check("b3_100", count3, 12'h100);
      step(); step(); step();
      check("b3_100_last", count3, 12'h100);
      step();
      check("b3_099", count3, 12'h099);

      // pause / resume from 10, pause while 07
      do_load(8'h10);
      do_start();
      for (int k = 0; k < 13; k++) step();
      check("pz_pre", count, 8'h07);
      pause = 1'b1; step(); pause = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("pz_hold_count", count, 8'h07);
         check("pz_state", state, 2'd2);
         step();
      end
      do_start();
      check("pz_resume_state", state, 2'd1);
      check("pz_resume_c0", count, 8'h07);
      step();
      check("pz_resume_c1", count, 8'h07);
      step();
      check("pz_resume_dec", count, 8'h06);

      // load while running at 05
      do_load(8'h10);
      do_start();
      for (int k = 0; k < 20; k++) step();
      check("lr_pre", count, 8'h05);
      do_load(8'h20);
      check("lr_count", count, 8'h20);
      check("lr_state", state, 2'd0);
      for (int i = 0; i < 5; i++) step();
      check("lr_hold", count, 8'h20);

      // start on zero count stays idle
      do_load(8'h00);
      do_start();
      seen_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) seen_done = 1'b1;
         step();
      end
      check("z_state", state, 2'd0);
      check("z_no_done", seen_done, 1'b0);
      check("z_zero", zero, 1'b1);

      // asynchronous reset just before the final tick
      do_load(8'h01);
      do_start();
      step(); step(); step();
      rst = 1'b0;
      #1;
      check("ar_rst_count", count, 8'h00);
      check("ar_rst_state", state, 2'd0);
      check("ar_rst_done", done, 1'b0);
      step();
      check("ar_rst_done2", done, 1'b0);
      rst = 1'b1;
      step();
      check("ar_post_done", done, 1'b0);
      check("ar_post_state", state, 2'd0);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
      // periodic reload 02,01,00 with done every 12 cycles
      ar_seq[0] = 8'h02; ar_seq[1] = 8'h01; ar_seq[2] = 8'h00;
      do_load(8'h02);
      do_start();
      for (int k = 0; k < 36; k++) begin
         check("rl_count", count, ar_seq[(k / 4) % 3]);
         check("rl_done", done, (k % 12) == 8);
         check("rl_state", state, 2'd1);
         step();
      end
`else
      ar_seq[0] = 8'h00; ar_seq[1] = 8'h00; ar_seq[2] = 8'h00;
      do_load(8'h02);
      do_start();
      for (int k = 0; k < 12; k++) step();
      check("nr_state", state, 2'd3);
      check("nr_count", count, ar_seq[0]);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
